// File: rtl/pipeline_ctrl_if.sv
// Hazard/stall control bundle between the pipeline datapath and pipeline_ctrl.
// master: datapath side (drives hazard info, receives controls).
// slave:  controller side (receives hazard info, drives controls).
interface pipeline_ctrl_if;
    // Hazard information from the datapath
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  ex_rt;
    logic        ex_mem_read;
    logic        mem_branch;
    logic        mem_zero;
    logic        mem_access;
    logic        dmem_ready;

    // Stage-register controls back to the datapath
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_m_en;
    logic        m_wb_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        ex_m_flush;
    logic        pc_src;
    logic        mem_err;
    logic [15:0] stall_cnt;

    modport master (
        output id_rs, id_rt, ex_rt, ex_mem_read,
        output mem_branch, mem_zero, mem_access, dmem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en,
        input  if_id_flush, id_ex_flush, ex_m_flush,
        input  pc_src, mem_err, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, ex_rt, ex_mem_read,
        input  mem_branch, mem_zero, mem_access, dmem_ready,
        output pc_en, if_id_en, id_ex_en, ex_m_en, m_wb_en,
        output if_id_flush, id_ex_flush, ex_m_flush,
        output pc_src, mem_err, stall_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: five-stage pipeline hazard and stall controller.
// Resolves load-use stalls, taken-branch flushes and data-memory wait
// freezes; a data-memory access that never completes within MEM_TIMEOUT
// cycles parks the pipeline in a sticky fault state until reset.
// Stage controls are combinational from state and inputs; state and
// counters are registered. MEM_TIMEOUT must be below 2**CNT_W.
// Optional feature macro: PIPE_STATS_EN adds a saturating 16-bit count of
// cycles with the PC held (stall_cnt); without it stall_cnt is tied to 0.
module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 8
) (
    input  logic           clk,
    input  logic           reset,
    pipeline_ctrl_if.slave bus
);

    localparam int unsigned STALL_W = 16;

    // Wait count at which one more unserved cycle means the timeout is hit
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;

    logic load_use_c;
    logic branch_c;
    logic freeze_c;

    logic pc_en_c;
    logic if_id_en_c;
    logic id_ex_en_c;
    logic ex_m_en_c;
    logic m_wb_en_c;
    logic if_id_flush_c;
    logic id_ex_flush_c;
    logic ex_m_flush_c;
    logic pc_src_c;
    logic mem_err_c;

    // Hazard detection: load in EX feeding a non-zero source of the ID instruction
    always_comb begin
        load_use_c = bus.ex_mem_read
                   && (bus.ex_rt != 5'd0)
                   && ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));
        branch_c   = bus.mem_branch && bus.mem_zero;
        freeze_c   = bus.mem_access && !bus.dmem_ready;
    end

    // State and wait-counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state and stage-control decode; freeze beats branch beats load-use
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        pc_en_c       = 1'b1;
        if_id_en_c    = 1'b1;
        id_ex_en_c    = 1'b1;
        ex_m_en_c     = 1'b1;
        m_wb_en_c     = 1'b1;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        ex_m_flush_c  = 1'b0;
        pc_src_c      = 1'b0;
        mem_err_c     = 1'b0;

        unique case (state_q)
            ST_RUN, ST_WAIT: begin
                if (freeze_c) begin
                    // Data memory busy: hold every stage, keep counting
                    pc_en_c    = 1'b0;
                    if_id_en_c = 1'b0;
                    id_ex_en_c = 1'b0;
                    ex_m_en_c  = 1'b0;
                    m_wb_en_c  = 1'b0;
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    if (wait_cnt_q >= LAST_WAIT) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                    if (branch_c) begin
                        // Taken branch squashes the three younger instructions
                        pc_src_c      = 1'b1;
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                        ex_m_flush_c  = 1'b1;
                    end else if (load_use_c) begin
                        // Hold PC and IF/ID one cycle, inject a bubble into EX
                        pc_en_c       = 1'b0;
                        if_id_en_c    = 1'b0;
                        id_ex_flush_c = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                // Memory fault: pipeline parked until reset
                pc_en_c    = 1'b0;
                if_id_en_c = 1'b0;
                id_ex_en_c = 1'b0;
                ex_m_en_c  = 1'b0;
                m_wb_en_c  = 1'b0;
                mem_err_c  = 1'b1;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase

        // During reset every stage register loads a bubble
        if (reset) begin
            pc_en_c       = 1'b1;
            if_id_en_c    = 1'b1;
            id_ex_en_c    = 1'b1;
            ex_m_en_c     = 1'b1;
            m_wb_en_c     = 1'b1;
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            ex_m_flush_c  = 1'b1;
            pc_src_c      = 1'b0;
            mem_err_c     = 1'b0;
        end
    end

    // Drive the control bundle
    assign bus.pc_en       = pc_en_c;
    assign bus.if_id_en    = if_id_en_c;
    assign bus.id_ex_en    = id_ex_en_c;
    assign bus.ex_m_en     = ex_m_en_c;
    assign bus.m_wb_en     = m_wb_en_c;
    assign bus.if_id_flush = if_id_flush_c;
    assign bus.id_ex_flush = id_ex_flush_c;
    assign bus.ex_m_flush  = ex_m_flush_c;
    assign bus.pc_src      = pc_src_c;
    assign bus.mem_err     = mem_err_c;

`ifdef PIPE_STATS_EN
    logic [STALL_W-1:0] stall_cnt_q;
    logic [STALL_W-1:0] stall_cnt_d;

    // Next stall count: bump on every cycle the PC is held, saturate at max
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en_c && (stall_cnt_q != {STALL_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    // Stall statistics register
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = STALL_W'(0);
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl (MEM_TIMEOUT = 4).
// Table vectors, hand-written multi-cycle sequences and a random phase,
// all compared against a cycle-level reference model of the controller.
module tb_pipeline_ctrl;

    localparam int unsigned TIMEOUT = 4;

    // Control vector: {pc_en,if_id_en,id_ex_en,ex_m_en,m_wb_en,
    //                  if_id_flush,id_ex_flush,ex_m_flush,pc_src,mem_err}
    localparam logic [9:0] V_RUN  = 10'b11111_000_0_0;
    localparam logic [9:0] V_LU   = 10'b00111_010_0_0;
    localparam logic [9:0] V_BR   = 10'b11111_111_1_0;
    localparam logic [9:0] V_FRZ  = 10'b00000_000_0_0;
    localparam logic [9:0] V_HALT = 10'b00000_000_0_1;
    localparam logic [9:0] V_RST  = 10'b11111_111_0_0;

`ifdef PIPE_STATS_EN
    localparam logic [15:0] STALL3 = 16'd3;
`else
    localparam logic [15:0] STALL3 = 16'd0;
`endif

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] ert;
        logic       lr;
        logic       br;
        logic       z;
        logic       acc;
        logic       rdy;
        logic [9:0] exp_v;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    pipeline_ctrl_if bus();

    pipeline_ctrl #(
        .MEM_TIMEOUT(TIMEOUT),
        .CNT_W      (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    bit m_halt;
    int m_wait;
    int m_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [9:0] act_vec();
        return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_m_en, bus.m_wb_en,
                bus.if_id_flush, bus.id_ex_flush, bus.ex_m_flush, bus.pc_src, bus.mem_err};
    endfunction

    // Expected controls from the current inputs and model state
    function automatic logic [9:0] model_vec();
        bit lu;
        lu = bus.ex_mem_read && (bus.ex_rt != 0)
             && (bus.ex_rt == bus.id_rs || bus.ex_rt == bus.id_rt);
        if (reset)                                return V_RST;
        if (m_halt)                               return V_HALT;
        if (bus.mem_access && !bus.dmem_ready)    return V_FRZ;
        if (bus.mem_branch && bus.mem_zero)       return V_BR;
        if (lu)                                   return V_LU;
        return V_RUN;
    endfunction

    function automatic logic [15:0] model_stall();
`ifdef PIPE_STATS_EN
        return 16'(m_stall);
`else
        return 16'd0;
`endif
    endfunction

    // Advance the model by one clock edge
    task automatic model_step(input logic [9:0] v);
        if (reset) begin
            m_halt  = 0;
            m_wait  = 0;
            m_stall = 0;
        end else begin
            if (!v[9] && m_stall < 65535) m_stall++;
            if (!m_halt) begin
                if (bus.mem_access && !bus.dmem_ready) begin
                    m_wait++;
                    if (m_wait >= int'(TIMEOUT)) m_halt = 1;
                end else begin
                    m_wait = 0;
                end
            end
        end
    endtask

    task automatic set_in(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] ert, input logic lr, input logic br,
                          input logic z, input logic acc, input logic rdy);
        reset           = r;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.ex_rt       = ert;
        bus.ex_mem_read = lr;
        bus.mem_branch  = br;
        bus.mem_zero    = z;
        bus.mem_access  = acc;
        bus.dmem_ready  = rdy;
    endtask

    // Compare one cycle (model always, fixed expectation optionally), then clock
    task automatic tick(input string name, input bit use_exp, input logic [9:0] exp_v);
        logic [9:0] mv;
        logic [9:0] av;
        #1;
        av = act_vec();
        mv = model_vec();
        check({name, "/model"}, 32'(av), 32'(mv));
        if (use_exp) check({name, "/fixed"}, 32'(av), 32'(exp_v));
        check({name, "/stall"}, 32'(bus.stall_cnt), 32'(model_stall()));
        @(posedge clk);
        model_step(mv);
        @(negedge clk);
    endtask

    vec_t tbl[12];

    initial begin
        m_halt  = 0;
        m_wait  = 0;
        m_stall = 0;

        tbl[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN};
        tbl[1]  = '{5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_LU};
        tbl[2]  = '{5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN};
        tbl[3]  = '{5'd2, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_LU};
        tbl[4]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN};
        tbl[5]  = '{5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_RUN};
        tbl[6]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_RUN};
        tbl[7]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, V_RUN};
        tbl[8]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, V_BR};
        tbl[9]  = '{5'd3, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, V_BR};
        tbl[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, V_RUN};
        tbl[11] = '{5'd9, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, V_LU};

        // Reset behaviour and post-reset state
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tick("reset_a", 1, V_RST);
        tick("reset_b", 1, V_RST);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("post_reset", 1, V_RUN);
        check("post_reset_stall", 32'(bus.stall_cnt), 32'd0);

        // Single-cycle vectors from RUN
        for (int i = 0; i < 12; i++) begin
            set_in(0, tbl[i].rs, tbl[i].rt, tbl[i].ert, tbl[i].lr,
                   tbl[i].br, tbl[i].z, tbl[i].acc, tbl[i].rdy);
            tick($sformatf("vec%0d", i), 1, tbl[i].exp_v);
        end

        // Three-cycle memory wait then release; stall count from a fresh reset
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("w3_reset", 1, V_RST);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) tick($sformatf("w3_frz%0d", i), 1, V_FRZ);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        tick("w3_release", 1, V_RUN);
        check("w3_stall", 32'(bus.stall_cnt), 32'(STALL3));

        // Timeout into HALT, ready afterwards ignored, reset recovers
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) tick($sformatf("to_frz%0d", i), 1, V_FRZ);
        tick("to_halt", 1, V_HALT);
        set_in(0, 5, 0, 5, 1, 1, 1, 1, 1);
        tick("to_halt_ready", 1, V_HALT);
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("to_reset", 1, V_RST);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("to_run", 1, V_RUN);

        // Branch pending while frozen resolves on the release cycle
        set_in(0, 0, 0, 0, 0, 1, 1, 1, 0);
        tick("bf_frz0", 1, V_FRZ);
        tick("bf_frz1", 1, V_FRZ);
        set_in(0, 0, 0, 0, 0, 1, 1, 1, 1);
        tick("bf_release", 1, V_BR);

        // Reset in WAIT clears the wait count
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick("rw_frz0", 1, V_FRZ);
        tick("rw_frz1", 1, V_FRZ);
        set_in(1, 0, 0, 0, 0, 0, 0, 1, 0);
        tick("rw_reset", 1, V_RST);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("rw_run", 1, V_RUN);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) tick($sformatf("rw_frz_again%0d", i), 1, V_FRZ);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("rw_release", 1, V_RUN);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom_range(0, 24) == 0),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
            tick($sformatf("rand%0d", i), 0, 10'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
